// File: rtl/reflet_int_to_float_if.sv
// Handshake bundle for the integer-to-float encoder.
// Master drives the integer side and out_ready; slave is the encoder.
interface reflet_int_to_float_if #(
    parameter int float_size = 32,
    parameter int int_size   = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [int_size-1:0]   in_int;
    logic                  in_signed;
    logic                  out_valid;
    logic                  out_ready;
    logic [float_size-1:0] out_float;

    modport master (
        output in_valid, in_int, in_signed, out_ready,
        input  in_ready, out_valid, out_float
    );

    modport slave (
        input  in_valid, in_int, in_signed, out_ready,
        output in_ready, out_valid, out_float
    );
endinterface

// File: rtl/reflet_int_to_float.sv
// Multi-cycle integer-to-float encoder.
// Normalises by one left shift per cycle, then packs {sign, exp, mnt}.
module reflet_int_to_float #(
    parameter int float_size = 32,
    parameter int int_size   = 32
) (
    input logic                  clk,
    input logic                  reset,
    reflet_int_to_float_if.slave bus
);
    function automatic int exp_size(input int fs);
        case (fs)
            16:      return 5;
            32:      return 8;
            64:      return 11;
            128:     return 15;
            default: return 8;
        endcase
    endfunction

    localparam int ES      = exp_size(float_size);
    localparam int MS      = float_size - 1 - ES;
    localparam int CW      = $clog2(int_size);
    localparam int BIAS    = (1 << (ES - 1)) - 1;
    localparam int EXP_MAX = (1 << ES) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [int_size-1:0]   mag_q, mag_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  sgn_q, sgn_d;
    logic [float_size-1:0] out_float_q, out_float_d;

    logic                     norm_done;
    logic                     in_neg;
    logic [31:0]              e_full;
    logic [int_size+MS-2:0]   frac_ext;
    logic [MS-1:0]            mnt;

    // Normalisation stops on zero or once the MSB is set
    assign norm_done = (mag_q == '0) || mag_q[int_size-1];
    assign in_neg    = bus.in_signed & bus.in_int[int_size-1];
    // Exponent kept 32 bits wide so bias + shift count cannot wrap
    assign e_full    = 32'(BIAS + int_size - 1) - 32'(cnt_q);
    // Bits below the MSB, zero-padded when the integer is narrower
    assign frac_ext  = {mag_q[int_size-2:0], {MS{1'b0}}};
    assign mnt       = frac_ext[int_size+MS-2 -: MS];

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            out_float_q <= '0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            out_float_q <= out_float_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = NORM;
            NORM: if (norm_done) state_d = PACK;
            PACK: state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture, shift and pack the datapath
    always_comb begin
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        out_float_d = out_float_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sgn_d = in_neg;
                    mag_d = in_neg ? (~bus.in_int + {{(int_size-1){1'b0}}, 1'b1})
                                   : bus.in_int;
                    cnt_d = '0;
                end
            end
            NORM: begin
                if (!norm_done) begin
                    mag_d = {mag_q[int_size-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PACK: begin
                if (mag_q == '0)
                    out_float_d = '0;
                else if (e_full >= 32'(EXP_MAX))
                    out_float_d = {sgn_q, {ES{1'b1}}, {MS{1'b0}}};
                else
                    out_float_d = {sgn_q, e_full[ES-1:0], mnt};
            end
            default: ;
        endcase
    end

    // Handshake outputs follow the registered state
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_float = out_float_q;
    end
endmodule

// File: tb/tb_reflet_int_to_float.sv
// Self-checking bench for reflet_int_to_float (32-bit and 16-bit floats).
// Random and directed integers against an arithmetic reference model.
module tb_reflet_int_to_float;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passed = 0;

    reflet_int_to_float_if #(.float_size(32), .int_size(32)) bus32();
    reflet_int_to_float_if #(.float_size(16), .int_size(32)) bus16();

    reflet_int_to_float #(.float_size(32), .int_size(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    reflet_int_to_float #(.float_size(16), .int_size(32)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: value = 2^p * (1 + f), exponent = bias + p, f truncated
    function automatic logic [63:0] ref_f(input logic [31:0] v, input bit s,
                                          input int fs, output int lat);
        int es, ms, bias, emax, p;
        bit neg;
        logic [63:0] m, r;
        es   = (fs == 16) ? 5 : 8;
        ms   = fs - 1 - es;
        bias = (1 << (es - 1)) - 1;
        emax = (1 << es) - 1;
        neg  = s && v[31];
        m    = neg ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
        if (m == 0) begin
            lat = 3;
            return 64'h0;
        end
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        lat = 3 + (31 - p);
        r = 64'(neg) << (fs - 1);
        if (bias + p >= emax) return r | (64'(emax) << ms);
        return r | (64'(bias + p) << ms) | (((m - (64'h1 << p)) << ms) >> p);
    endfunction

    function automatic logic cur_ov(input int sel);
        return (sel == 0) ? bus32.out_valid : bus16.out_valid;
    endfunction

    function automatic logic cur_ir(input int sel);
        return (sel == 0) ? bus32.in_ready : bus16.in_ready;
    endfunction

    function automatic logic [31:0] cur_of(input int sel);
        return (sel == 0) ? bus32.out_float : {16'h0, bus16.out_float};
    endfunction

    task automatic drive(input int sel, input logic vld, input logic [31:0] v, input logic s);
        if (sel == 0) begin
            bus32.in_valid  = vld;
            bus32.in_int    = v;
            bus32.in_signed = s;
        end else begin
            bus16.in_valid  = vld;
            bus16.in_int    = v;
            bus16.in_signed = s;
        end
    endtask

    task automatic set_ordy(input int sel, input logic r);
        if (sel == 0) bus32.out_ready = r;
        else bus16.out_ready = r;
    endtask

    // Accept one integer, count edges to out_valid, check value and latency
    task automatic run_to_done(input int sel, input logic [31:0] v, input bit s, input string tag);
        int lat, edges;
        logic [63:0] exp;
        exp = ref_f(v, s, (sel == 0) ? 32 : 16, lat);
        @(negedge clk);
        check({tag, " in_ready"}, 64'(cur_ir(sel)), 64'h1);
        drive(sel, 1'b1, v, s);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) drive(sel, 1'b0, $urandom, 1'($urandom));
        end while (!cur_ov(sel) && edges < 100);
        check({tag, " latency"}, 64'(edges), 64'(lat));
        check({tag, " value"}, 64'(cur_of(sel)), exp);
    endtask

    task automatic take(input int sel, input string tag);
        @(negedge clk);
        set_ordy(sel, 1'b1);
        @(posedge clk);
        #1;
        set_ordy(sel, 1'b0);
        check({tag, " out_valid low"}, 64'(cur_ov(sel)), 64'h0);
        check({tag, " in_ready back"}, 64'(cur_ir(sel)), 64'h1);
    endtask

    task automatic convert(input int sel, input logic [31:0] v, input bit s, input string tag);
        run_to_done(sel, v, s, tag);
        take(sel, tag);
    endtask

    initial begin
        logic [31:0] saved;
        logic [31:0] rv;
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);

        #12;
        check("rst in_ready", 64'(bus32.in_ready), 64'h1);
        check("rst out_valid", 64'(bus32.out_valid), 64'h0);
        check("rst out_float", 64'(bus32.out_float), 64'h0);
        check("rst16 out_float", 64'(bus16.out_float), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        convert(0, 32'h0000_0001, 1'b1, "one");
        convert(0, 32'hFFFF_FFFF, 1'b1, "minus_one");
        convert(0, 32'h0000_0000, 1'b1, "zero");
        convert(0, 32'h8000_0000, 1'b1, "min_int");
        convert(0, 32'h8000_0000, 1'b0, "u_2p31");
        convert(0, 32'h7FFF_FFFF, 1'b1, "max_int");
        convert(0, 32'h00FF_FFFF, 1'b0, "exact24");

        run_to_done(0, 32'h0000_1234, 1'b0, "stall");
        saved = bus32.out_float;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(0, 1'b1, $urandom, 1'($urandom));
            @(posedge clk);
            #1;
            drive(0, 1'b0, 32'h0, 1'b0);
            check("stall hold", 64'(bus32.out_float), 64'(saved));
            check("stall in_ready", 64'(bus32.in_ready), 64'h0);
            check("stall out_valid", 64'(bus32.out_valid), 64'h1);
        end
        take(0, "stall");
        convert(0, 32'h0000_0005, 1'b0, "after_stall");

        convert(1, 32'h8000_0000, 1'b0, "f16 +inf");
        convert(1, 32'hFFFF_0000, 1'b1, "f16 -inf");
        convert(1, 32'hFFFF_FFFF, 1'b1, "f16 -1");
        convert(1, 32'h0000_0000, 1'b0, "f16 zero");

        for (int i = 0; i < 24; i++) begin
            rv = $urandom >> $urandom_range(0, 31);
            convert(0, rv, 1'($urandom), "rand32");
        end
        for (int i = 0; i < 16; i++) begin
            rv = $urandom >> $urandom_range(0, 31);
            convert(1, rv, 1'($urandom), "rand16");
        end

        @(negedge clk);
        drive(0, 1'b1, 32'h0000_0001, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort out_valid", 64'(bus32.out_valid), 64'h0);
        check("abort in_ready", 64'(bus32.in_ready), 64'h1);
        @(negedge clk);
        reset = 1'b1;
        convert(0, 32'h0000_0003, 1'b1, "three");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
